// File: rtl/ccu_r_mux_lock_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ccu_r_mux_lock_arbiter_pkg : shared types for the CCU R lock mux   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ccu_r_mux_lock_arbiter_pkg;

  typedef enum logic [0:0] {
    L_IDLE   = 1'b0,
    L_LOCKED = 1'b1
  } lock_fsm_t;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } ccu_r_t;

endpackage
`default_nettype wire

// File: rtl/ccu_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ccu_rr_pick : first set request at or after ptr, modulo NumReq     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ccu_rr_pick
  import ccu_r_mux_lock_arbiter_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   sel_o,
  output logic              valid_o
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] idx;

  always_comb begin
    sel_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NumReq; i++) begin
      // ptr < NumReq, so a single conditional subtract wraps the sum.
      sum = {1'b0, ptr_i} + (IdxW+1)'(i);
      if (sum >= (IdxW+1)'(NumReq)) begin
        sum = sum - (IdxW+1)'(NumReq);
      end
      idx = sum[IdxW-1:0];
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        sel_o   = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ccu_r_mux_lock_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ccu_r_mux_lock_arbiter : R-channel lock arbiter and owner mux      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ccu_r_mux_lock_arbiter
  import ccu_r_mux_lock_arbiter_pkg::*;
#(
  parameter int  NumReq   = 2,
  parameter type r_chan_t = logic,
  parameter int  IdxW     = idx_width(NumReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      lock_req_i,
  output logic [NumReq-1:0]      lock_gnt_o,
  input  logic [NumReq-1:0]      lock_free_i,
  input  logic [NumReq-1:0]      r_valid_i,
  input  r_chan_t [NumReq-1:0]   r_i,
  output logic [NumReq-1:0]      r_ready_o,
  output logic                   r_valid_o,
  output r_chan_t                r_o,
  input  logic                   r_ready_i,
  output logic                   locked_o,
  output logic [IdxW-1:0]        owner_o,
  output logic                   err_o
);

  lock_fsm_t         state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              err_q, err_d;
  logic [NumReq-1:0] gnt;
  logic [NumReq-1:0] owner_oh;
  logic [IdxW-1:0]   pick_sel;
  logic              pick_valid;

  ccu_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req_i   (lock_req_i),
    .ptr_i   (rr_ptr_q),
    .sel_o   (pick_sel),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    gnt      = '0;
    owner_oh = '0;
    owner_oh[owner_q] = 1'b1;
    case (state_q)
      L_IDLE: begin
        if (pick_valid) begin
          gnt[pick_sel] = 1'b1;
          state_d       = L_LOCKED;
          owner_d       = pick_sel;
          rr_ptr_d      = (pick_sel == IdxW'(NumReq-1)) ? '0 : pick_sel + 1'b1;
        end
        if ((|lock_free_i) || (|r_valid_i)) begin
          err_d = 1'b1;
        end
      end
      L_LOCKED: begin
        // Only the owner's free releases; dropping its request does not.
        if (lock_free_i[owner_q]) begin
          state_d = L_IDLE;
          owner_d = '0;
        end
        if ((|(lock_free_i & ~owner_oh)) || (|(r_valid_i & ~owner_oh))) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = L_IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= L_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  // Grant is combinational, so it must also be forced low while reset is held.
  assign lock_gnt_o = rst_i ? '0 : gnt;
  assign locked_o   = (state_q == L_LOCKED);
  assign owner_o    = owner_q;
  assign err_o      = err_q;

  always_comb begin
    r_valid_o = 1'b0;
    r_o       = '0;
    r_ready_o = '0;
    if (state_q == L_LOCKED) begin
      r_valid_o          = r_valid_i[owner_q];
      r_o                = r_i[owner_q];
      r_ready_o[owner_q] = r_ready_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccu_r_mux_lock_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ccu_r_mux_lock_arbiter : directed bench for the R lock arbiter  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ccu_r_mux_lock_arbiter;
  import ccu_r_mux_lock_arbiter_pkg::*;

  logic           clk;
  logic           rst;
  logic [1:0]     lock_req;
  logic [1:0]     lock_gnt;
  logic [1:0]     lock_free;
  logic [1:0]     r_valid_in;
  ccu_r_t [1:0]   r_in;
  logic [1:0]     r_ready_out;
  logic           r_valid_out;
  ccu_r_t         r_out;
  logic           r_ready_in;
  logic           locked;
  logic [0:0]     owner;
  logic           err;

  int n_checks = 0;
  int n_fail   = 0;

  ccu_r_mux_lock_arbiter #(
    .NumReq   (2),
    .r_chan_t (ccu_r_t)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .lock_req_i  (lock_req),
    .lock_gnt_o  (lock_gnt),
    .lock_free_i (lock_free),
    .r_valid_i   (r_valid_in),
    .r_i         (r_in),
    .r_ready_o   (r_ready_out),
    .r_valid_o   (r_valid_out),
    .r_o         (r_out),
    .r_ready_i   (r_ready_in),
    .locked_o    (locked),
    .owner_o     (owner),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ccu_r_t mk_beat(input logic [3:0] id, input logic [31:0] data,
                                     input logic last);
    ccu_r_t b;
    b.id = id; b.data = data; b.resp = 2'b00; b.last = last; b.user = 1'b0;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lock_req   = '0;
    lock_free  = '0;
    r_valid_in = '0;
    r_in       = '0;
    r_ready_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    lock_req   = 2'b01;
    r_valid_in = 2'b11;
    r_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (lock_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", lock_gnt); end
    n_checks++;
    if ({locked, owner, err} !== 3'b000) begin n_fail++; $display("FAIL reset_state: got locked/owner/err %b want 000", {locked, owner, err}); end
    n_checks++;
    if ({r_valid_out, r_ready_out} !== 3'b000 || r_out !== '0) begin
      n_fail++; $display("FAIL reset_r: got valid %b ready %b r %h want all zero", r_valid_out, r_ready_out, r_out);
    end
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_burst();
    ccu_r_t exp;
    do_reset();
    lock_req = 2'b01;
    #1;
    n_checks++;
    if (lock_gnt !== 2'b01) begin n_fail++; $display("FAIL burst_gnt: got %b want 01", lock_gnt); end
    step();
    lock_req = 2'b00;
    #1;
    n_checks++;
    if (locked !== 1'b1 || owner !== 1'b0 || lock_gnt !== 2'b00) begin
      n_fail++; $display("FAIL burst_locked: got locked %b owner %b gnt %b want 1 0 00", locked, owner, lock_gnt);
    end
    r_ready_in = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp = mk_beat(4'h3, 32'hA000_0000 + 32'(b), (b == 3));
      r_valid_in = 2'b01;
      r_in[0]    = exp;
      #1;
      n_checks++;
      if (r_valid_out !== 1'b1 || r_out !== exp || r_ready_out !== 2'b01) begin
        n_fail++; $display("FAIL burst_beat%0d: got valid %b r %h ready %b want 1 %h 01", b, r_valid_out, r_out, r_ready_out, exp);
      end
      step();
    end
    r_valid_in = 2'b00;
    r_ready_in = 1'b0;
    lock_free  = 2'b01;
    #1;
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL burst_free_cycle: got locked %b want 1", locked); end
    step();
    lock_free = 2'b00;
    #1;
    n_checks++;
    if (locked !== 1'b0 || owner !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL burst_released: got locked %b owner %b err %b want 0 0 0", locked, owner, err);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    do_reset();
    lock_req   = 2'b11;
    r_ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_checks++;
      if (lock_gnt !== exp_gnt || locked !== 1'b0) begin
        n_fail++; $display("FAIL rr_grant%0d: got gnt %b locked %b want %b 0", k, lock_gnt, locked, exp_gnt);
      end
      step();
      r_valid_in = exp_gnt;
      r_in       = {mk_beat(4'h1, 32'h1111_0000 + 32'(k), 1'b1), mk_beat(4'h0, 32'h0000_0000 + 32'(k), 1'b1)};
      lock_free  = exp_gnt;
      #1;
      n_checks++;
      if (locked !== 1'b1 || owner !== 1'(k % 2) || r_ready_out !== exp_gnt || lock_gnt !== 2'b00) begin
        n_fail++; $display("FAIL rr_owner%0d: got locked %b owner %b ready %b gnt %b want 1 %0d %b 00", k, locked, owner, r_ready_out, lock_gnt, k % 2, exp_gnt);
      end
      step();
      r_valid_in = 2'b00;
      lock_free  = 2'b00;
    end
    lock_req = 2'b00;
    #1;
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL rr_err: got %b want 0", err); end
  endtask

  task automatic test_nonowner_valid();
    ccu_r_t a, b;
    a = mk_beat(4'h5, 32'hDEAD_0000, 1'b1);
    b = mk_beat(4'h6, 32'hBEEF_0001, 1'b1);
    do_reset();
    lock_req = 2'b10;
    #1;
    n_checks++;
    if (lock_gnt !== 2'b10) begin n_fail++; $display("FAIL nov_gnt: got %b want 10", lock_gnt); end
    step();
    lock_req   = 2'b00;
    r_valid_in = 2'b11;
    r_in       = {b, a};
    r_ready_in = 1'b1;
    #1;
    n_checks++;
    if (r_valid_out !== 1'b1 || r_out !== b || r_ready_out !== 2'b10) begin
      n_fail++; $display("FAIL nov_mux: got valid %b r %h ready %b want 1 %h 10", r_valid_out, r_out, r_ready_out, b);
    end
    step();
    r_valid_in = 2'b00;
    #1;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL nov_err_set: got %b want 1", err); end
    step();
    n_checks++;
    if (err !== 1'b1 || owner !== 1'b1) begin n_fail++; $display("FAIL nov_err_sticky: got err %b owner %b want 1 1", err, owner); end
  endtask

  task automatic test_bad_free();
    do_reset();
    lock_req = 2'b01;
    step();
    lock_req  = 2'b00;
    lock_free = 2'b10;
    step();
    lock_free = 2'b00;
    #1;
    n_checks++;
    if (owner !== 1'b0 || locked !== 1'b1 || err !== 1'b1) begin
      n_fail++; $display("FAIL bad_free: got owner %b locked %b err %b want 0 1 1", owner, locked, err);
    end
  endtask

  task automatic test_stall_then_free();
    ccu_r_t last_beat;
    int     handshakes;
    handshakes = 0;
    last_beat  = mk_beat(4'h7, 32'hCAFE_F00D, 1'b1);
    do_reset();
    lock_req = 2'b01;
    step();
    lock_req   = 2'b10;
    r_valid_in = 2'b01;
    r_in[0]    = last_beat;
    r_ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (r_valid_out && r_ready_in) handshakes++;
      n_checks++;
      if (r_valid_out !== 1'b1 || r_out !== last_beat || r_ready_out !== 2'b00) begin
        n_fail++; $display("FAIL stall%0d: got valid %b r %h ready %b want 1 %h 00", c, r_valid_out, r_out, r_ready_out, last_beat);
      end
      step();
    end
    r_ready_in = 1'b1;
    lock_free  = 2'b01;
    #1;
    if (r_valid_out && r_ready_in) handshakes++;
    n_checks++;
    if (r_ready_out !== 2'b01 || locked !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got ready %b locked %b want 01 1", r_ready_out, locked);
    end
    step();
    r_valid_in = 2'b00;
    lock_free  = 2'b00;
    r_ready_in = 1'b0;
    #1;
    if (r_valid_out && r_ready_in) handshakes++;
    n_checks++;
    if (locked !== 1'b0 || lock_gnt !== 2'b10) begin
      n_fail++; $display("FAIL stall_idle: got locked %b gnt %b want 0 10", locked, lock_gnt);
    end
    step();
    lock_req = 2'b00;
    #1;
    n_checks++;
    if (locked !== 1'b1 || owner !== 1'b1) begin
      n_fail++; $display("FAIL stall_next_owner: got locked %b owner %b want 1 1", locked, owner);
    end
    n_checks++;
    if (handshakes !== 1 || err !== 1'b0) begin
      n_fail++; $display("FAIL stall_once: got handshakes %0d err %b want 1 0", handshakes, err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    lock_req = 2'b01;
    step();
    lock_req   = 2'b00;
    r_valid_in = 2'b01;
    r_in[0]    = mk_beat(4'h2, 32'h1234_5678, 1'b0);
    r_ready_in = 1'b1;
    #1;
    n_checks++;
    if (r_valid_out !== 1'b1 || locked !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre: got valid %b locked %b want 1 1", r_valid_out, locked);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({locked, owner, err, r_valid_out, r_ready_out, lock_gnt} !== 8'b0 || r_out !== '0) begin
      n_fail++; $display("FAIL arst_outputs: got locked %b owner %b err %b valid %b ready %b gnt %b r %h want all zero",
                         locked, owner, err, r_valid_out, r_ready_out, lock_gnt, r_out);
    end
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    lock_req = 2'b10;
    #1;
    n_checks++;
    if (lock_gnt !== 2'b10) begin n_fail++; $display("FAIL arst_gnt10: got %b want 10", lock_gnt); end
    lock_req = 2'b11;
    #1;
    n_checks++;
    if (lock_gnt !== 2'b01) begin n_fail++; $display("FAIL arst_ptr0: got gnt %b want 01", lock_gnt); end
    step();
    lock_req = 2'b00;
    #1;
    n_checks++;
    if (locked !== 1'b1 || owner !== 1'b0) begin
      n_fail++; $display("FAIL arst_owner: got locked %b owner %b want 1 0", locked, owner);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic_burst();
    test_round_robin();
    test_nonowner_valid();
    test_bad_free();
    test_stall_then_free();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
